// File: rtl/fifo_package.sv
// fifo_package: shared sizing for the SRAM-backed FIFO controller and its handshake interface.
package fifo_package;
    parameter int DATA_WIDTH = 32;
    parameter int ADDR_WIDTH = 4;
    parameter int DEPTH      = 16;
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// sram_fifo_ctrl_if: push/pop valid-ready bundle between the FIFO controller and its producer/consumer.
interface sram_fifo_ctrl_if;
    logic                              push_valid_i;
    logic [fifo_package::DATA_WIDTH-1:0] push_data_i;
    logic                              push_ready_o;
    logic                              pop_valid_o;
    logic [fifo_package::DATA_WIDTH-1:0] pop_data_o;
    logic                              pop_ready_i;
    modport master (
        output push_valid_i, push_data_i, pop_ready_i,
        input  push_ready_o, pop_valid_o, pop_data_o
    );
    modport slave (
        input  push_valid_i, push_data_i, pop_ready_i,
        output push_ready_o, pop_valid_o, pop_data_o
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO over a single-port SRAM with one access per cycle, write/read arbitration
// by a toggling priority bit, and a 2-entry output buffer absorbing the one-cycle read latency.
module sram_fifo_ctrl
    import fifo_package::*;
(
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  flush_i,
    sram_fifo_ctrl_if.slave       fifo_if,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic                  sram_we_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    output logic [ADDR_WIDTH+1:0] count_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int MW = ADDR_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 2;
    localparam logic [MW-1:0]         MEM_MAX  = MW'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [MW-1:0]         mem_cnt_q, mem_cnt_d;
    logic                  rd_pend_q, rd_pend_d, prio_q, prio_d;
    logic [DATA_WIDTH-1:0] ob_q [2];
    logic [DATA_WIDTH-1:0] ob_d [2];
    logic [1:0]            ob_cnt_q, ob_cnt_d, ob_mid;
    logic [2:0]            occ;
    logic                  pop_hs, rd_req, push_rdy, wr_gnt, rd_gnt;

    always_comb begin
        pop_hs    = (ob_cnt_q != 2'd0) && fifo_if.pop_ready_i;
        occ       = 3'(ob_cnt_q) + 3'(rd_pend_q) - 3'(pop_hs);
        rd_req    = (mem_cnt_q != '0) && (occ < 3'd2);
        push_rdy  = (mem_cnt_q < MEM_MAX) && (!rd_req || !prio_q) && !flush_i;
        wr_gnt    = fifo_if.push_valid_i && push_rdy;
        rd_gnt    = rd_req && !wr_gnt && !flush_i;
        wr_ptr_d  = wr_gnt ? ((wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1)) : wr_ptr_q;
        rd_ptr_d  = rd_gnt ? ((rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ADDR_WIDTH'(1)) : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + MW'(wr_gnt) - MW'(rd_gnt);
        rd_pend_d = rd_gnt;
        prio_d    = prio_q ^ (rd_req && fifo_if.push_valid_i && (mem_cnt_q < MEM_MAX));
        // pop shifts the head out first, so the returning read lands behind what remains
        ob_mid    = ob_cnt_q - 2'(pop_hs);
        ob_cnt_d  = ob_mid + 2'(rd_pend_q);
        ob_d      = ob_q;
        if (pop_hs) ob_d[0] = ob_q[1];
        if (rd_pend_q) ob_d[ob_mid[0]] = sram_rdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst_i || flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
            ob_cnt_q  <= 2'd0;
            prio_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            rd_pend_q <= rd_pend_d;
            ob_cnt_q  <= ob_cnt_d;
            prio_q    <= prio_d;
        end
    end

    always_ff @(posedge clk) ob_q <= ob_d;

    assign sram_we_o            = wr_gnt;
    assign sram_addr_o          = wr_gnt ? wr_ptr_q : rd_ptr_q;
    assign sram_wdata_o         = fifo_if.push_data_i;
    assign fifo_if.push_ready_o = push_rdy;
    assign fifo_if.pop_valid_o  = ob_cnt_q != 2'd0;
    assign fifo_if.pop_data_o   = ob_q[0];
    assign count_o              = CW'(mem_cnt_q) + CW'(rd_pend_q) + CW'(ob_cnt_q);
    assign full_o               = mem_cnt_q == MEM_MAX;
    assign empty_o              = count_o == '0;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: vector table for cycle-exact behaviour, directed corner sequences,
// and randomized traffic scored against a queue model of FIFO contents.
module tb_sram_fifo_ctrl;
    import fifo_package::*;

    logic clk = 1'b0;
    logic rst, flush;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata, sram_rdata;
    logic                  sram_we;
    logic [ADDR_WIDTH+1:0] count;
    logic                  full, empty;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    sram_fifo_ctrl_if bus ();

    sram_fifo_ctrl dut (
        .clk          (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .fifo_if      (bus),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_we_o    (sram_we),
        .sram_rdata_i (sram_rdata),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
    );

    always_ff @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        sram_rdata <= mem[sram_addr];
    end

    typedef struct {
        logic        pv;
        logic [31:0] pd;
        logic        pr;
        logic        epv;
        logic [31:0] epd;
        logic        erdy;
        logic        ewe;
        logic [3:0]  eaddr;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t        tbl [14];
    int          total = 0;
    int          bad = 0;
    int          stall = 0;
    logic [31:0] q [$];
    logic        last_push, last_pop, saw_full;
    logic        s_pv, s_rdy, s_full, s_empty, s_we;
    logic [31:0] s_pd;
    logic [5:0]  s_cnt;
    logic [3:0]  s_addr;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b0;
        bus.push_valid_i = 1'b0;
        bus.push_data_i = '0;
        bus.pop_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        stall = 0;
    endtask

    // one clock of traffic; the queue model is checked before the edge and updated after it
    task automatic cycle(input logic pv, input logic [31:0] pd, input logic pr, input logic fl);
        @(negedge clk);
        bus.push_valid_i = pv;
        bus.push_data_i = pd;
        bus.pop_ready_i = pr;
        flush = fl;
        #1;
        s_pv = bus.pop_valid_o;
        s_pd = bus.pop_data_o;
        s_rdy = bus.push_ready_o;
        s_full = full;
        s_empty = empty;
        s_cnt = count;
        s_we = sram_we;
        s_addr = sram_addr;
        last_push = pv && s_rdy;
        last_pop = pr && s_pv;
        chk("count", s_cnt, q.size());
        chk("empty", s_empty, q.size() == 0);
        if (s_pv) begin
            chk("pop_nonempty", q.size() != 0, 1);
            if (q.size() != 0) chk("pop_data", s_pd, q[0]);
        end
        if (fl) chk("ready_in_flush", s_rdy, 0);
        if (q.size() == DEPTH + 2) begin
            chk("full_at_cap", s_full, 1);
            chk("ready_at_cap", s_rdy, 0);
        end
        if (q.size() < DEPTH) chk("not_full", s_full, 0);
        stall = (q.size() != 0 && !s_pv) ? stall + 1 : 0;
        chk("stall", stall > 6, 0);
        if (s_full) saw_full = 1'b1;
        @(posedge clk);
        if (last_pop && q.size() != 0) void'(q.pop_front());
        if (last_push) q.push_back(pd);
        if (fl) q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_push, n_pop, got;
        logic [31:0] got_d;
        rst = 1'b1;
        flush = 1'b0;
        saw_full = 1'b0;
        bus.push_valid_i = 1'b0;
        bus.push_data_i = '0;
        bus.pop_ready_i = 1'b0;
        tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 4'd0, 6'd0};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 4'd0, 6'd1};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 4'd1, 6'd1};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 4'd1, 6'd1};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 4'd1, 6'd0};
        tbl[5]  = '{1'b1, 32'hB0,        1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4'd1, 6'd0};
        tbl[6]  = '{1'b1, 32'hB1,        1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4'd2, 6'd1};
        tbl[7]  = '{1'b1, 32'hB2,        1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'd1, 6'd2};
        tbl[8]  = '{1'b1, 32'hB2,        1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 4'd3, 6'd2};
        tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hB0,        1'b0, 1'b0, 4'd2, 6'd3};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hB0,        1'b0, 1'b0, 4'd3, 6'd3};
        tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hB1,        1'b1, 1'b0, 4'd4, 6'd2};
        tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hB2,        1'b1, 1'b0, 4'd4, 6'd1};
        tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 4'd4, 6'd0};

        do_reset();
        chk("rst_pv", bus.pop_valid_o, 0);
        chk("rst_cnt", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_we", sram_we, 0);
        chk("rst_addr", sram_addr, 0);
        chk("rst_ready", bus.push_ready_o, 1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.push_valid_i = tbl[i].pv;
            bus.push_data_i = tbl[i].pd;
            bus.pop_ready_i = tbl[i].pr;
            #1;
            chk($sformatf("v%0d_pop_valid", i), bus.pop_valid_o, tbl[i].epv);
            if (tbl[i].epv) chk($sformatf("v%0d_pop_data", i), bus.pop_data_o, tbl[i].epd);
            chk($sformatf("v%0d_push_ready", i), bus.push_ready_o, tbl[i].erdy);
            chk($sformatf("v%0d_we", i), sram_we, tbl[i].ewe);
            chk($sformatf("v%0d_addr", i), sram_addr, tbl[i].eaddr);
            chk($sformatf("v%0d_count", i), count, tbl[i].ecnt);
            chk($sformatf("v%0d_empty", i), empty, tbl[i].ecnt == 0);
            chk($sformatf("v%0d_full", i), full, 0);
        end

        // continuous push and pop: order via model, rate near one per two cycles
        do_reset();
        n_push = 0;
        n_pop = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 32'h1000 + n_push, 1'b1, 1'b0);
            if (last_push) n_push++;
            if (last_pop) n_pop++;
        end
        chk("thru_push", n_push >= 40, 1);
        chk("thru_pop", n_pop >= 40, 1);

        // fill to capacity with the consumer stalled, then drain in order
        do_reset();
        n_push = 0;
        for (int i = 0; i < 200 && n_push < 18; i++) begin
            cycle(1'b1, n_push, 1'b0, 1'b0);
            if (last_push) n_push++;
        end
        chk("fill_accepted", n_push, 18);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
        chk("fill_full", s_full, 1);
        chk("fill_ready", s_rdy, 0);
        chk("fill_count", s_cnt, 18);
        n_pop = 0;
        for (int i = 0; i < 200 && n_pop < 18; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            if (last_pop) begin
                chk("drain_order", s_pd, n_pop);
                n_pop++;
            end
        end
        chk("drain_count", n_pop, 18);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("drain_empty", s_empty, 1);

        // flush while a read is in flight
        do_reset();
        cycle(1'b1, 32'hCAFE_0001, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_rd_issued_we", s_we, 0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_count", s_cnt, 0);
        chk("flush_empty", s_empty, 1);
        chk("flush_pv", s_pv, 0);
        cycle(1'b1, 32'hBEEF_0002, 1'b1, 1'b0);
        got = 0;
        got_d = '0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
            if (last_pop) begin
                got = 1;
                got_d = s_pd;
            end
        end
        chk("flush_next_seen", got, 1);
        chk("flush_next_data", got_d, 32'hBEEF_0002);

        // reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, i[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.push_valid_i = 1'b1;
        bus.pop_ready_i = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        bus.push_valid_i = 1'b0;
        bus.pop_ready_i = 1'b0;
        #1;
        chk("mrst_pv", bus.pop_valid_o, 0);
        chk("mrst_cnt", count, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_full", full, 0);
        chk("mrst_we", sram_we, 0);
        chk("mrst_addr", sram_addr, 0);
        chk("mrst_ready", bus.push_ready_o, 1);
        q.delete();
        stall = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // randomized traffic in fill-biased, drain-biased and mixed phases
        do_reset();
        saw_full = 1'b0;
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 500; i++) begin
                int pvp, prp;
                logic fl;
                pvp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
                prp = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
                fl = (ph == 2) && ($urandom_range(0, 99) == 0);
                cycle($urandom_range(0, 99) < pvp, $urandom, $urandom_range(0, 99) < prp, fl);
            end
        end
        chk("saw_full", saw_full, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
